// File: rtl/tl_ul_master_driver_pkg.sv
// Shared TL-UL widths, opcodes, transaction-type codes and FSM encodings for the master driver.
// Bus widths default here and may be overridden by defining the TL_* macros before this file.
`ifndef TL_ADDR_BITS
`define TL_ADDR_BITS 32
`endif
`ifndef TL_SIZE_BITS
`define TL_SIZE_BITS 3
`endif
`ifndef TL_SOURCE_BITS
`define TL_SOURCE_BITS 4
`endif
`ifndef TL_DATA_BYTES
`define TL_DATA_BYTES 8
`endif

package tl_ul_master_driver_pkg;
    localparam int ADDR_W     = `TL_ADDR_BITS;
    localparam int SIZE_W     = `TL_SIZE_BITS;
    localparam int SRC_W      = `TL_SOURCE_BITS;
    localparam int DATA_BYTES = `TL_DATA_BYTES;
    localparam int DATA_W     = DATA_BYTES * 8;
    localparam int LANE_W     = $clog2(DATA_BYTES);

    // Largest legal beat size: one full data bus
    localparam logic [SIZE_W-1:0] MAX_SIZE = SIZE_W'(LANE_W);

    localparam logic [2:0] TL_OP_PUT_FULL        = 3'd0;
    localparam logic [2:0] TL_OP_PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] TL_OP_GET             = 3'd4;
    localparam logic [2:0] TL_OP_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_OP_ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [1:0] {
        TT_GET        = 2'd0,
        TT_PUTFULL    = 2'd1,
        TT_PUTPARTIAL = 2'd2,
        TT_RESERVED   = 2'd3
    } txn_type_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_A_SEND = 2'd1,
        ST_D_WAIT = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    function automatic logic [2:0] a_opcode_for(input txn_type_e t);
        case (t)
            TT_GET:     return TL_OP_GET;
            TT_PUTFULL: return TL_OP_PUT_FULL;
            default:    return TL_OP_PUT_PARTIAL;
        endcase
    endfunction

    function automatic logic [2:0] d_opcode_for(input txn_type_e t);
        return (t == TT_GET) ? TL_OP_ACCESS_ACK_DATA : TL_OP_ACCESS_ACK;
    endfunction

    function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a,
                                                     input logic [SIZE_W-1:0] s);
        return a & ~((ADDR_W'(1) << s) - ADDR_W'(1));
    endfunction
endpackage

// File: rtl/tl_ul_master_driver_if.sv
// TL-UL A and D channel bundle; master drives A and d_ready, slave drives a_ready and D.
interface tl_ul_master_driver_if;
    import tl_ul_master_driver_pkg::*;

    logic                  a_valid;
    logic                  a_ready;
    logic [2:0]            a_opcode;
    logic [2:0]            a_param;
    logic [SIZE_W-1:0]     a_size;
    logic [SRC_W-1:0]      a_source;
    logic [ADDR_W-1:0]     a_address;
    logic [DATA_BYTES-1:0] a_mask;
    logic [DATA_W-1:0]     a_data;

    logic                  d_valid;
    logic                  d_ready;
    logic [2:0]            d_opcode;
    logic [1:0]            d_param;
    logic [SIZE_W-1:0]     d_size;
    logic [SRC_W-1:0]      d_source;
    logic                  d_denied;
    logic [DATA_W-1:0]     d_data;
    logic                  d_corrupt;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt,
        output d_ready
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt,
        input  d_ready
    );
endinterface

// File: rtl/tl_ul_master_driver_mask_gen.sv
// Byte-lane mask for a naturally aligned beat of 2**size bytes; purely combinational.
module tl_mask_gen
    import tl_ul_master_driver_pkg::*;
(
    input  logic [SIZE_W-1:0]     size,
    input  logic [LANE_W-1:0]     addr_lo,
    output logic [DATA_BYTES-1:0] mask
);
    // A lane is enabled when it falls in the same 2**size block as the address
    always_comb begin
        mask = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            mask[i] = ((LANE_W'(i) >> size) == (addr_lo >> size));
        end
    end
endmodule

// File: rtl/tl_ul_master_driver.sv
// Single-outstanding TL-UL master: one A beat one cycle after accept, held until a_ready; D accepted only in D_WAIT.
// Optional watchdog under TL_MASTER_TIMEOUT_EN aborts after TIMEOUT_CYCLES cycles with resp_error and timeout set.
module tl_ul_master_driver
    import tl_ul_master_driver_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_transaction,
    input  logic [1:0]            transaction_type,
    input  logic [ADDR_W-1:0]     address,
    input  logic [SIZE_W-1:0]     size,
    input  logic [SRC_W-1:0]      source,
    input  logic [DATA_W-1:0]     write_data,
    input  logic [DATA_BYTES-1:0] write_mask,
    tl_ul_master_driver_if.master tl,
    output logic [DATA_W-1:0]     read_data,
    output logic                  transaction_done,
    output logic                  resp_error,
    output logic                  timeout,
    output logic                  busy
);
    state_e                state;
    txn_type_e             cmd_type;
    txn_type_e             start_type;
    logic [SRC_W-1:0]      cmd_source;
    logic [DATA_BYTES-1:0] lane_mask;
    logic                  accept;
    logic                  cmd_ok;
    logic                  a_fire;
    logic                  d_fire;
    logic                  d_bad;
    logic                  unused_d_fields;

    assign start_type = txn_type_e'(transaction_type);
    assign accept     = start_transaction && (state == ST_IDLE || state == ST_DONE);
    assign cmd_ok     = (start_type != TT_RESERVED) && (size <= MAX_SIZE);
    assign a_fire     = tl.a_valid && tl.a_ready;
    assign d_fire     = tl.d_valid && tl.d_ready;
    assign d_bad      = tl.d_denied || tl.d_corrupt || (tl.d_source != cmd_source) ||
                        (tl.d_opcode != d_opcode_for(cmd_type));
    assign unused_d_fields = ^{tl.d_param, tl.d_size};

    tl_mask_gen u_mask_gen (
        .size    (size),
        .addr_lo (address[LANE_W-1:0]),
        .mask    (lane_mask)
    );

`ifdef TL_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             timeout_q;
    assign timeout = timeout_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            cmd_type         <= TT_GET;
            cmd_source       <= '0;
            tl.a_valid       <= 1'b0;
            tl.a_opcode      <= '0;
            tl.a_param       <= '0;
            tl.a_size        <= '0;
            tl.a_source      <= '0;
            tl.a_address     <= '0;
            tl.a_mask        <= '0;
            tl.a_data        <= '0;
            tl.d_ready       <= 1'b0;
            read_data        <= '0;
            transaction_done <= 1'b0;
            resp_error       <= 1'b0;
            busy             <= 1'b0;
`ifdef TL_MASTER_TIMEOUT_EN
            tmo_cnt          <= '0;
            timeout_q        <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        cmd_type   <= start_type;
                        cmd_source <= source;
`ifdef TL_MASTER_TIMEOUT_EN
                        tmo_cnt    <= '0;
                        timeout_q  <= 1'b0;
`endif
                        if (cmd_ok) begin
                            state            <= ST_A_SEND;
                            busy             <= 1'b1;
                            transaction_done <= 1'b0;
                            resp_error       <= 1'b0;
                            tl.a_valid       <= 1'b1;
                            tl.a_opcode      <= a_opcode_for(start_type);
                            tl.a_param       <= '0;
                            tl.a_size        <= size;
                            tl.a_source      <= source;
                            tl.a_address     <= align_addr(address, size);
                            tl.a_mask        <= (start_type == TT_PUTPARTIAL) ?
                                                (write_mask & lane_mask) : lane_mask;
                            tl.a_data        <= (start_type == TT_GET) ? '0 : write_data;
                        end else begin
                            // Malformed command completes immediately without touching the bus
                            state            <= ST_DONE;
                            transaction_done <= 1'b1;
                            resp_error       <= 1'b1;
                        end
                    end
                end
                ST_A_SEND: begin
                    if (a_fire) begin
                        state      <= ST_D_WAIT;
                        tl.a_valid <= 1'b0;
                        tl.d_ready <= 1'b1;
                    end
                end
                ST_D_WAIT: begin
                    if (d_fire) begin
                        state            <= ST_DONE;
                        tl.d_ready       <= 1'b0;
                        busy             <= 1'b0;
                        transaction_done <= 1'b1;
                        resp_error       <= d_bad;
                        if (cmd_type == TT_GET && tl.d_opcode == TL_OP_ACCESS_ACK_DATA) begin
                            read_data <= tl.d_data;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
`ifdef TL_MASTER_TIMEOUT_EN
            // Placed after the case so an expiry overrides any same-cycle handshake
            if (busy) begin
                if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state            <= ST_DONE;
                    tl.a_valid       <= 1'b0;
                    tl.d_ready       <= 1'b0;
                    busy             <= 1'b0;
                    transaction_done <= 1'b1;
                    resp_error       <= 1'b1;
                    timeout_q        <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_tl_ul_master_driver.sv
// Randomized scoreboard bench for tl_ul_master_driver with a reactive TL-UL slave.
module tb_tl_ul_master_driver;
    import tl_ul_master_driver_pkg::*;

    localparam int TMO = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start_transaction;
    logic [1:0]            transaction_type;
    logic [ADDR_W-1:0]     address;
    logic [SIZE_W-1:0]     size;
    logic [SRC_W-1:0]      source;
    logic [DATA_W-1:0]     write_data;
    logic [DATA_BYTES-1:0] write_mask;
    logic [DATA_W-1:0]     read_data;
    logic                  transaction_done;
    logic                  resp_error;
    logic                  timeout;
    logic                  busy;

    always #5 clk = ~clk;

    tl_ul_master_driver_if tl();

    tl_ul_master_driver #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk               (clk),
        .rst               (rst),
        .start_transaction (start_transaction),
        .transaction_type  (transaction_type),
        .address           (address),
        .size              (size),
        .source            (source),
        .write_data        (write_data),
        .write_mask        (write_mask),
        .tl                (tl),
        .read_data         (read_data),
        .transaction_done  (transaction_done),
        .resp_error        (resp_error),
        .timeout           (timeout),
        .busy              (busy)
    );

    typedef struct {
        logic [1:0]  typ;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  src;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        int          a_delay;
        int          d_delay;
        logic [2:0]  d_op;
        logic [3:0]  d_src;
        logic        denied;
        logic        corrupt;
        logic [63:0] d_data;
        bit          respond;
    } txn_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [7:0]  mask;
        logic [63:0] data;
        logic [2:0]  size;
        logic [3:0]  src;
        int          cycles;
    } exp_a_t;

    typedef struct {
        logic        err;
        logic [63:0] rd;
        logic        tmo;
        logic        busy1;
    } exp_r_t;

    txn_t   plan_q[$];
    exp_a_t exp_a_q[$];
    exp_r_t exp_r_q[$];
    int     n_chk  = 0;
    int     n_fail = 0;
    logic [63:0] rd_model;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Reference: TL-UL rules applied arithmetically to one command
    function automatic exp_a_t model_a(input txn_t t);
        exp_a_t e;
        int nb;
        int off;
        logic [7:0] lane;
        nb     = 1 << t.size;
        e.addr = t.addr & ~(32'(nb) - 32'd1);
        off    = int'(e.addr % 32'd8);
        lane   = 8'(((1 << nb) - 1) << off);
        e.op   = (t.typ == 2'd0) ? 3'd4 : (t.typ == 2'd1) ? 3'd0 : 3'd1;
        e.mask = (t.typ == 2'd2) ? (t.wmask & lane) : lane;
        e.data = (t.typ == 2'd0) ? 64'd0 : t.wdata;
        e.size = t.size;
        e.src  = t.src;
        e.cycles = t.a_delay + 1;
        return e;
    endfunction

    function automatic txn_t blank();
        txn_t t;
        t.typ = 0; t.addr = 0; t.size = 0; t.src = 0; t.wdata = 0; t.wmask = 0;
        t.a_delay = 0; t.d_delay = 0; t.d_op = 0; t.d_src = 0;
        t.denied = 0; t.corrupt = 0; t.d_data = 0; t.respond = 1;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t = blank();
        t.typ     = ($urandom % 10 == 0) ? 2'd3 : 2'($urandom % 3);
        t.size    = ($urandom % 10 == 0) ? 3'(4 + $urandom % 4) : 3'($urandom % 4);
        t.addr    = $urandom;
        t.src     = 4'($urandom);
        t.wdata   = {$urandom, $urandom};
        t.wmask   = 8'($urandom);
        t.a_delay = int'($urandom % 5);
        t.d_delay = int'($urandom % 5);
        t.d_op    = ($urandom % 5 == 0) ? 3'($urandom) : ((t.typ == 2'd0) ? 3'd1 : 3'd0);
        t.d_src   = ($urandom % 7 == 0) ? 4'($urandom) : t.src;
        t.denied  = ($urandom % 10 == 0);
        t.corrupt = ($urandom % 10 == 0);
        t.d_data  = {$urandom, $urandom};
        return t;
    endfunction

    task automatic issue(input txn_t t);
        bit ok;
        exp_r_t r;
        ok = (t.typ != 2'd3) && (t.size <= 3'd3);
        if (ok) begin
            exp_a_q.push_back(model_a(t));
            plan_q.push_back(t);
        end
        r.busy1 = ok;
        r.tmo   = 1'b0;
        if (!ok) begin
            r.err = 1'b1;
        end else if (!t.respond) begin
            r.err = 1'b1;
            r.tmo = 1'b1;
        end else begin
            r.err = t.denied | t.corrupt | (t.d_src != t.src) |
                    (t.d_op != ((t.typ == 2'd0) ? 3'd1 : 3'd0));
            if (t.typ == 2'd0 && t.d_op == 3'd1) rd_model = t.d_data;
        end
        r.rd = rd_model;
        exp_r_q.push_back(r);
        @(negedge clk);
        start_transaction = 1'b1;
        transaction_type  = t.typ;
        address           = t.addr;
        size              = t.size;
        source            = t.src;
        write_data        = t.wdata;
        write_mask        = t.wmask;
        @(negedge clk);
        // Scramble the command inputs so latching is exercised
        start_transaction = 1'b0;
        transaction_type  = 2'($urandom);
        address           = $urandom;
        size              = 3'($urandom);
        source            = 4'($urandom);
        write_data        = {$urandom, $urandom};
        write_mask        = 8'($urandom);
    endtask

    task automatic wait_done(input string name, output int cycles);
        cycles = 1;
        while (!transaction_done && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        if (!transaction_done) chk({name, "_done_bound"}, 64'(transaction_done), 64'd1);
    endtask

    // Reactive slave: stalls a_ready, injects ignored D beats, then answers per plan
    initial begin : responder
        txn_t p;
        forever begin
            @(negedge clk);
            if (tl.a_valid && plan_q.size() != 0 && !rst) begin
                p = plan_q.pop_front();
                for (int i = 0; i < p.a_delay; i++) begin
                    tl.d_valid  = 1'($urandom_range(0, 1));
                    tl.d_opcode = 3'($urandom);
                    tl.d_source = 4'($urandom);
                    tl.d_data   = {$urandom, $urandom};
                    @(negedge clk);
                end
                tl.d_valid = 1'b0;
                tl.a_ready = 1'b1;
                @(negedge clk);
                tl.a_ready = 1'b0;
                if (p.respond) begin
                    repeat (p.d_delay) @(negedge clk);
                    tl.d_opcode  = p.d_op;
                    tl.d_source  = p.d_src;
                    tl.d_denied  = p.denied;
                    tl.d_corrupt = p.corrupt;
                    tl.d_data    = p.d_data;
                    tl.d_valid   = 1'b1;
                    @(negedge clk);
                    tl.d_valid   = 1'b0;
                    tl.d_denied  = 1'b0;
                    tl.d_corrupt = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        bit     st_prev = 1'b0;
        bit     pending = 1'b0;
        int     acyc    = 0;
        exp_a_t ea;
        exp_r_t er;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                if (pending && exp_r_q.size() != 0) void'(exp_r_q.pop_front());
                pending = 1'b0;
                st_prev = 1'b0;
                acyc    = 0;
            end else begin
                if (st_prev) begin
                    chk("exp_result_available", 64'(exp_r_q.size() != 0), 64'd1);
                    if (exp_r_q.size() != 0) begin
                        chk("busy_after_accept", 64'(busy), 64'(exp_r_q[0].busy1));
                        if (exp_r_q[0].busy1) begin
                            chk("done_cleared", 64'(transaction_done), 64'd0);
                            chk("err_cleared", 64'(resp_error), 64'd0);
                            chk("tmo_cleared", 64'(timeout), 64'd0);
                        end
                        pending = 1'b1;
                    end
                end
                if (pending && transaction_done) begin
                    er = exp_r_q.pop_front();
                    pending = 1'b0;
                    chk("resp_error", 64'(resp_error), 64'(er.err));
                    chk("read_data", read_data, er.rd);
                    chk("timeout", 64'(timeout), 64'(er.tmo));
                    chk("busy_in_done", 64'(busy), 64'd0);
                end
                chk("a_valid_d_ready_exclusive", 64'(tl.a_valid & tl.d_ready), 64'd0);
                if (tl.a_valid) begin
                    if (exp_a_q.size() == 0) begin
                        chk("a_valid_unexpected", 64'(tl.a_valid), 64'd0);
                    end else begin
                        ea = exp_a_q[0];
                        acyc++;
                        chk("a_opcode", 64'(tl.a_opcode), 64'(ea.op));
                        chk("a_param", 64'(tl.a_param), 64'd0);
                        chk("a_size", 64'(tl.a_size), 64'(ea.size));
                        chk("a_source", 64'(tl.a_source), 64'(ea.src));
                        chk("a_address", 64'(tl.a_address), 64'(ea.addr));
                        chk("a_mask", 64'(tl.a_mask), 64'(ea.mask));
                        chk("a_data", tl.a_data, ea.data);
                        if (tl.a_ready) begin
                            chk("a_valid_cycles", 64'(acyc), 64'(ea.cycles));
                            void'(exp_a_q.pop_front());
                            acyc = 0;
                        end
                    end
                end
                st_prev = start_transaction;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        txn_t t;
        int   cyc;
        rst = 1'b1;
        start_transaction = 1'b0;
        transaction_type = '0; address = '0; size = '0; source = '0;
        write_data = '0; write_mask = '0;
        tl.a_ready = 1'b0; tl.d_valid = 1'b0; tl.d_opcode = '0; tl.d_param = '0;
        tl.d_size = '0; tl.d_source = '0; tl.d_denied = 1'b0; tl.d_data = '0;
        tl.d_corrupt = 1'b0;
        rd_model = '0;
        repeat (3) @(negedge clk);
        chk("rst_a_valid", 64'(tl.a_valid), 64'd0);
        chk("rst_d_ready", 64'(tl.d_ready), 64'd0);
        chk("rst_done", 64'(transaction_done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_read_data", read_data, 64'd0);
        rst = 1'b0;

        // GET, immediate ready, AccessAckData
        t = blank(); t.typ = 0; t.addr = 32'h1000; t.size = 3; t.src = 1;
        t.d_op = 1; t.d_src = 1; t.d_data = 64'hDEADBEEF00C0FFEE;
        issue(t); wait_done("get_basic", cyc);

        // PUTPARTIAL with a_ready stalled four cycles
        t = blank(); t.typ = 2; t.addr = 32'h3004; t.size = 3; t.wmask = 8'hF0;
        t.wdata = 64'hFFFFFFFF00000000; t.a_delay = 4; t.d_op = 0; t.d_src = 0;
        issue(t); wait_done("putpartial_stall", cyc);

        // PUTFULL answered with the wrong source
        t = blank(); t.typ = 1; t.addr = 32'h4000; t.size = 2; t.src = 2;
        t.wdata = 64'h11223344; t.d_op = 0; t.d_src = 3;
        issue(t); wait_done("source_mismatch", cyc);

        // Denied GET, then a new start directly from DONE
        t = blank(); t.typ = 0; t.addr = 32'h5008; t.size = 3; t.src = 4;
        t.d_op = 1; t.d_src = 4; t.denied = 1; t.d_data = 64'h0123456789ABCDEF;
        issue(t); wait_done("denied", cyc);
        t = blank(); t.typ = 1; t.addr = 32'h6002; t.size = 1; t.src = 4;
        t.wdata = 64'hA5A5; t.d_op = 0; t.d_src = 4; t.d_delay = 2;
        issue(t); wait_done("restart_from_done", cyc);

        // Malformed commands: reserved type and oversize
        t = blank(); t.typ = 3; t.addr = 32'h10; t.size = 2;
        issue(t); wait_done("reserved_type", cyc);
        chk("reserved_type_latency", 64'(cyc), 64'd1);
        t = blank(); t.typ = 0; t.addr = 32'h20; t.size = 4;
        issue(t); wait_done("oversize", cyc);

        // Reset asserted while waiting on D
        t = blank(); t.typ = 0; t.addr = 32'h2000; t.size = 2; t.src = 5; t.respond = 0;
        issue(t);
        for (int i = 0; i < 20 && !tl.d_ready; i++) @(negedge clk);
        chk("rst_test_reached_dwait", 64'(tl.d_ready), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst_a_valid", 64'(tl.a_valid), 64'd0);
        chk("midrst_d_ready", 64'(tl.d_ready), 64'd0);
        chk("midrst_done", 64'(transaction_done), 64'd0);
        chk("midrst_err", 64'(resp_error), 64'd0);
        chk("midrst_timeout", 64'(timeout), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_read_data", read_data, 64'd0);
        chk("midrst_a_address", 64'(tl.a_address), 64'd0);
        chk("midrst_a_data", tl.a_data, 64'd0);
        rd_model = '0;
        @(negedge clk);
        rst = 1'b0;

`ifdef TL_MASTER_TIMEOUT_EN
        t = blank(); t.typ = 0; t.addr = 32'h7000; t.size = 3; t.src = 6;
        t.a_delay = 3; t.respond = 0;
        issue(t); wait_done("timeout", cyc);
        chk("timeout_cycle", 64'(cyc), 64'(TMO));
`endif

        for (int n = 0; n < 60; n++) begin
            t = rand_txn();
            issue(t);
            wait_done("random", cyc);
        end

        repeat (4) @(negedge clk);
        chk("exp_a_drained", 64'(exp_a_q.size()), 64'd0);
        chk("exp_r_drained", 64'(exp_r_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
